// File: rtl/register_status_mc.sv
// Multi-lane register status file: per-register busy bit and newest producer ROB tag,
// with intra-group rename bypass, commit clears and branch checkpoints restorable in one cycle.
module register_status_mc #(
   parameter int REG     = 4,
   parameter int ROB     = 2,
   parameter int LANES   = 2,
   parameter int COMMITS = 2,
   parameter int CKPT    = 4
) (
   input  logic                         clk,
   input  logic                         globalReset,
   input  logic                         flush,
   input  logic [LANES-1:0]             renValid,
   input  logic [LANES-1:0]             renWe,
   input  logic [LANES*(REG+1)-1:0]     destReg,
   input  logic [LANES*(ROB+1)-1:0]     destROB,
   input  logic [LANES*(REG+1)-1:0]     rs1,
   input  logic [LANES*(REG+1)-1:0]     rs2,
   output logic [LANES*(ROB+1)-1:0]     rob1,
   output logic [LANES*(ROB+1)-1:0]     rob2,
   output logic [LANES-1:0]             busy1,
   output logic [LANES-1:0]             busy2,
   input  logic [COMMITS-1:0]           comValid,
   input  logic [COMMITS*(REG+1)-1:0]   comReg,
   input  logic [COMMITS*(ROB+1)-1:0]   comROB,
   input  logic                         ckptTake,
   output logic [$clog2(CKPT)-1:0]      ckptId,
   output logic                         ckptFull,
   input  logic                         ckptRelease,
   input  logic                         restore,
   input  logic [$clog2(CKPT)-1:0]      restoreId
);
   localparam int NREG = 1 << (REG + 1);
   localparam int RW   = REG + 1;
   localparam int TW   = ROB + 1;
   localparam int IW   = $clog2(CKPT);
   localparam int CW   = IW + 1;

   logic [NREG-1:0] busy_q, busy_d;
   logic [TW-1:0]   tag_q [NREG];
   logic [TW-1:0]   tag_d [NREG];
   logic [NREG-1:0] ckb_q [CKPT];
   logic [NREG-1:0] ckb_d [CKPT];
   logic [TW-1:0]   ckt_q [CKPT][NREG];
   logic [TW-1:0]   ckt_d [CKPT][NREG];
   logic [IW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic            rel_ok, take_ok;

   assign ckptId   = tail_q;
   assign ckptFull = (count_q == CW'(CKPT));

   // Lookup priority: x0, then older-lane bypass, then same-cycle commit, then table.
   always_comb begin
      logic [RW-1:0] rs;
      logic          lb;
      logic [TW-1:0] lt;
      busy1 = '0;
      busy2 = '0;
      rob1  = '0;
      rob2  = '0;
      rs    = '0;
      lb    = 1'b0;
      lt    = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         for (int unsigned s = 0; s < 2; s++) begin
            rs = (s == 0) ? rs1[l*RW +: RW] : rs2[l*RW +: RW];
            lb = busy_q[rs];
            lt = tag_q[rs];
            for (int unsigned j = 0; j < COMMITS; j++)
               if (comValid[j] && comReg[j*RW +: RW] == rs &&
                   comROB[j*TW +: TW] == tag_q[rs] && busy_q[rs])
                  lb = 1'b0;
            for (int unsigned k = 0; k < l; k++)
               if (renValid[k] && renWe[k] && destReg[k*RW +: RW] == rs) begin
                  lb = 1'b1;
                  lt = destROB[k*TW +: TW];
               end
            if (rs == '0) begin
               lb = 1'b0;
               lt = '0;
            end
            if (s == 0) begin
               busy1[l]           = lb;
               rob1[l*TW +: TW]   = lt;
            end else begin
               busy2[l]           = lb;
               rob2[l*TW +: TW]   = lt;
            end
         end
      end
   end

   always_comb begin
      logic [RW-1:0] cr;
      logic [TW-1:0] ct;
      logic [RW-1:0] dr;
      busy_d  = busy_q;
      tag_d   = tag_q;
      ckb_d   = ckb_q;
      ckt_d   = ckt_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      cr      = '0;
      ct      = '0;
      dr      = '0;
      rel_ok  = ckptRelease && (count_q != '0);
      take_ok = ckptTake && !ckptFull;
      // Commits scrub every slot by tag, so a restore never revives a retired producer.
      for (int unsigned j = 0; j < COMMITS; j++) begin
         cr = comReg[j*RW +: RW];
         ct = comROB[j*TW +: TW];
         if (comValid[j] && busy_q[cr] && tag_q[cr] == ct)
            busy_d[cr] = 1'b0;
         for (int unsigned s = 0; s < CKPT; s++)
            if (comValid[j] && ckt_q[IW'(s)][cr] == ct)
               ckb_d[IW'(s)][cr] = 1'b0;
      end
      if (rel_ok)
         head_d = head_q + IW'(1);
      if (restore) begin
         busy_d  = ckb_d[restoreId];
         tag_d   = ckt_q[restoreId];
         tail_d  = restoreId;
         count_d = {1'b0, IW'(restoreId - head_d)};
      end else begin
         for (int unsigned l = 0; l < LANES; l++) begin
            dr = destReg[l*RW +: RW];
            if (renValid[l] && renWe[l] && dr != '0) begin
               busy_d[dr] = 1'b1;
               tag_d[dr]  = destROB[l*TW +: TW];
            end
         end
         if (take_ok) begin
            ckb_d[tail_q] = busy_d;
            ckt_d[tail_q] = tag_d;
            tail_d        = tail_q + IW'(1);
         end
         count_d = count_q + CW'(take_ok) - CW'(rel_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (globalReset) begin
         busy_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int unsigned i = 0; i < NREG; i++)
            tag_q[i] <= '0;
         for (int unsigned s = 0; s < CKPT; s++) begin
            ckb_q[s] <= '0;
            for (int unsigned i = 0; i < NREG; i++)
               ckt_q[s][i] <= '0;
         end
      end else if (flush) begin
         busy_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         busy_q  <= busy_d;
         tag_q   <= tag_d;
         ckb_q   <= ckb_d;
         ckt_q   <= ckt_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
endmodule

// File: tb/tb_register_status_mc.sv
// Scenario bench for register_status_mc: expectations queued at stimulus time, compared at negedge.
module tb_register_status_mc;
   logic       clk = 1'b0;
   logic       globalReset, flush;
   logic [1:0] renValid, renWe;
   logic [9:0] destReg, rs1, rs2;
   logic [5:0] destROB, rob1, rob2;
   logic [1:0] busy1, busy2;
   logic [1:0] comValid;
   logic [9:0] comReg;
   logic [5:0] comROB;
   logic       ckptTake, ckptFull, ckptRelease, restore;
   logic [1:0] ckptId, restoreId;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int         kind;
      int         lane;
      logic [3:0] val;
      string      name;
   } exp_t;
   exp_t sb[$];
   exp_t e;

   localparam int K_B1 = 0, K_R1 = 1, K_B2 = 2, K_R2 = 3, K_ID = 4, K_FULL = 5;

   register_status_mc #(.REG(4), .ROB(2), .LANES(2), .COMMITS(2), .CKPT(4)) dut (
      .clk(clk), .globalReset(globalReset), .flush(flush),
      .renValid(renValid), .renWe(renWe), .destReg(destReg), .destROB(destROB),
      .rs1(rs1), .rs2(rs2), .rob1(rob1), .rob2(rob2), .busy1(busy1), .busy2(busy2),
      .comValid(comValid), .comReg(comReg), .comROB(comROB),
      .ckptTake(ckptTake), .ckptId(ckptId), .ckptFull(ckptFull),
      .ckptRelease(ckptRelease), .restore(restore), .restoreId(restoreId)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   function automatic logic [3:0] obs(input int kind, input int lane);
      case (kind)
         K_B1:    return {3'b000, busy1[lane]};
         K_R1:    return {1'b0, rob1[lane*3 +: 3]};
         K_B2:    return {3'b000, busy2[lane]};
         K_R2:    return {1'b0, rob2[lane*3 +: 3]};
         K_ID:    return {2'b00, ckptId};
         default: return {3'b000, ckptFull};
      endcase
   endfunction

   task automatic push(input int kind, input int lane, input logic [3:0] val, input string name);
      exp_t x;
      x.kind = kind; x.lane = lane; x.val = val; x.name = name;
      sb.push_back(x);
   endtask

   task automatic idle();
      flush = 0; renValid = '0; renWe = '0; destReg = '0; destROB = '0;
      rs1 = '0; rs2 = '0; comValid = '0; comReg = '0; comROB = '0;
      ckptTake = 0; ckptRelease = 0; restore = 0; restoreId = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic ren(input int l, input int d, input int t);
      renValid[l] = 1'b1; renWe[l] = 1'b1;
      destReg[l*5 +: 5] = 5'(d); destROB[l*3 +: 3] = 3'(t);
   endtask

   task automatic src(input int l, input int a, input int b);
      rs1[l*5 +: 5] = 5'(a); rs2[l*5 +: 5] = 5'(b);
   endtask

   task automatic com(input int j, input int r, input int t);
      comValid[j] = 1'b1; comReg[j*5 +: 5] = 5'(r); comROB[j*3 +: 3] = 3'(t);
   endtask

   task automatic test_reset();
      globalReset = 1; idle();
      @(posedge clk); @(posedge clk); #1;
      globalReset = 0;
      src(0, 5, 31); src(1, 5, 0);
      push(K_B1, 0, 0, "reset_busy1_l0"); push(K_R1, 0, 0, "reset_rob1_l0");
      push(K_B2, 0, 0, "reset_busy2_l0"); push(K_R2, 0, 0, "reset_rob2_l0");
      push(K_ID, 0, 0, "reset_ckptId"); push(K_FULL, 0, 0, "reset_ckptFull");
      @(negedge clk);
      while (sb.size() != 0) begin e = sb.pop_front(); checks++; if (obs(e.kind, e.lane) !== e.val) begin errors++; $display("FAIL %s: got %0h required %0h", e.name, obs(e.kind, e.lane), e.val); end end
      tick();
   endtask

   task automatic test_bypass();
      ren(0, 5, 3); src(1, 5, 0); src(0, 5, 0);
      push(K_B1, 1, 1, "bypass_busy1_l1"); push(K_R1, 1, 3, "bypass_rob1_l1");
      push(K_B1, 0, 0, "no_self_bypass_l0"); push(K_B2, 1, 0, "bypass_x0_busy2_l1");
      @(negedge clk);
      while (sb.size() != 0) begin e = sb.pop_front(); checks++; if (obs(e.kind, e.lane) !== e.val) begin errors++; $display("FAIL %s: got %0h required %0h", e.name, obs(e.kind, e.lane), e.val); end end
      tick();
      src(0, 5, 0);
      push(K_B1, 0, 1, "table_busy_x5"); push(K_R1, 0, 3, "table_rob_x5");
      @(negedge clk);
      while (sb.size() != 0) begin e = sb.pop_front(); checks++; if (obs(e.kind, e.lane) !== e.val) begin errors++; $display("FAIL %s: got %0h required %0h", e.name, obs(e.kind, e.lane), e.val); end end
      tick();
   endtask

   task automatic test_commit();
      com(0, 5, 3); src(0, 0, 5);
      push(K_B2, 0, 0, "commit_bypass_busy2"); push(K_R2, 0, 3, "commit_bypass_rob2");
      @(negedge clk);
      while (sb.size() != 0) begin e = sb.pop_front(); checks++; if (obs(e.kind, e.lane) !== e.val) begin errors++; $display("FAIL %s: got %0h required %0h", e.name, obs(e.kind, e.lane), e.val); end end
      tick();
      src(0, 5, 0);
      push(K_B1, 0, 0, "commit_cleared_x5");
      @(negedge clk);
      while (sb.size() != 0) begin e = sb.pop_front(); checks++; if (obs(e.kind, e.lane) !== e.val) begin errors++; $display("FAIL %s: got %0h required %0h", e.name, obs(e.kind, e.lane), e.val); end end
      tick();
      ren(0, 5, 3);
      tick();
      com(0, 5, 2); src(0, 0, 5);
      push(K_B2, 0, 1, "stale_commit_busy2"); push(K_R2, 0, 3, "stale_commit_rob2");
      @(negedge clk);
      while (sb.size() != 0) begin e = sb.pop_front(); checks++; if (obs(e.kind, e.lane) !== e.val) begin errors++; $display("FAIL %s: got %0h required %0h", e.name, obs(e.kind, e.lane), e.val); end end
      tick();
      src(0, 5, 0);
      push(K_B1, 0, 1, "stale_commit_kept_busy");
      @(negedge clk);
      while (sb.size() != 0) begin e = sb.pop_front(); checks++; if (obs(e.kind, e.lane) !== e.val) begin errors++; $display("FAIL %s: got %0h required %0h", e.name, obs(e.kind, e.lane), e.val); end end
      tick();
   endtask

   task automatic test_commit_rename();
      ren(0, 7, 1);
      tick();
      com(1, 7, 1); ren(0, 7, 4); src(1, 7, 0);
      push(K_B1, 1, 1, "bypass_over_commit_busy"); push(K_R1, 1, 4, "bypass_over_commit_rob");
      @(negedge clk);
      while (sb.size() != 0) begin e = sb.pop_front(); checks++; if (obs(e.kind, e.lane) !== e.val) begin errors++; $display("FAIL %s: got %0h required %0h", e.name, obs(e.kind, e.lane), e.val); end end
      tick();
      src(0, 0, 7);
      push(K_B2, 0, 1, "rename_wins_busy_x7"); push(K_R2, 0, 4, "rename_wins_tag_x7");
      @(negedge clk);
      while (sb.size() != 0) begin e = sb.pop_front(); checks++; if (obs(e.kind, e.lane) !== e.val) begin errors++; $display("FAIL %s: got %0h required %0h", e.name, obs(e.kind, e.lane), e.val); end end
      tick();
   endtask

   task automatic test_back_to_back();
      ren(0, 10, 1); ren(1, 10, 2); src(1, 10, 0);
      push(K_B1, 1, 1, "same_dest_bypass_busy"); push(K_R1, 1, 1, "same_dest_bypass_rob");
      @(negedge clk);
      while (sb.size() != 0) begin e = sb.pop_front(); checks++; if (obs(e.kind, e.lane) !== e.val) begin errors++; $display("FAIL %s: got %0h required %0h", e.name, obs(e.kind, e.lane), e.val); end end
      tick();
      src(0, 10, 0);
      push(K_B1, 0, 1, "same_dest_busy"); push(K_R1, 0, 2, "higher_lane_wins_tag");
      @(negedge clk);
      while (sb.size() != 0) begin e = sb.pop_front(); checks++; if (obs(e.kind, e.lane) !== e.val) begin errors++; $display("FAIL %s: got %0h required %0h", e.name, obs(e.kind, e.lane), e.val); end end
      tick();
   endtask

   task automatic test_restore();
      ren(0, 3, 2); ckptTake = 1;
      push(K_ID, 0, 0, "take_ckptId0"); push(K_FULL, 0, 0, "take_not_full");
      @(negedge clk);
      while (sb.size() != 0) begin e = sb.pop_front(); checks++; if (obs(e.kind, e.lane) !== e.val) begin errors++; $display("FAIL %s: got %0h required %0h", e.name, obs(e.kind, e.lane), e.val); end end
      tick();
      ren(0, 3, 6);
      push(K_ID, 0, 1, "tail_after_take");
      @(negedge clk);
      while (sb.size() != 0) begin e = sb.pop_front(); checks++; if (obs(e.kind, e.lane) !== e.val) begin errors++; $display("FAIL %s: got %0h required %0h", e.name, obs(e.kind, e.lane), e.val); end end
      tick();
      com(0, 3, 2); src(0, 3, 0);
      push(K_B1, 0, 1, "old_tag_commit_busy"); push(K_R1, 0, 6, "old_tag_commit_rob");
      @(negedge clk);
      while (sb.size() != 0) begin e = sb.pop_front(); checks++; if (obs(e.kind, e.lane) !== e.val) begin errors++; $display("FAIL %s: got %0h required %0h", e.name, obs(e.kind, e.lane), e.val); end end
      tick();
      restore = 1; restoreId = 2'd0;
      tick();
      src(0, 3, 0);
      push(K_B1, 0, 0, "restored_x3_not_busy"); push(K_R1, 0, 2, "restored_x3_tag");
      push(K_ID, 0, 0, "restore_tail"); push(K_FULL, 0, 0, "restore_empty");
      @(negedge clk);
      while (sb.size() != 0) begin e = sb.pop_front(); checks++; if (obs(e.kind, e.lane) !== e.val) begin errors++; $display("FAIL %s: got %0h required %0h", e.name, obs(e.kind, e.lane), e.val); end end
      tick();
   endtask

   task automatic test_ckpt_full();
      for (int i = 0; i < 4; i++) begin
         ckptTake = 1;
         push(K_ID, 0, 4'(i), "fill_ckptId"); push(K_FULL, 0, 0, "fill_not_full");
         @(negedge clk);
         while (sb.size() != 0) begin e = sb.pop_front(); checks++; if (obs(e.kind, e.lane) !== e.val) begin errors++; $display("FAIL %s: got %0h required %0h", e.name, obs(e.kind, e.lane), e.val); end end
         tick();
      end
      ckptTake = 1;
      push(K_FULL, 0, 1, "full_after_4"); push(K_ID, 0, 0, "tail_wrapped");
      @(negedge clk);
      while (sb.size() != 0) begin e = sb.pop_front(); checks++; if (obs(e.kind, e.lane) !== e.val) begin errors++; $display("FAIL %s: got %0h required %0h", e.name, obs(e.kind, e.lane), e.val); end end
      tick();
      ckptRelease = 1;
      push(K_FULL, 0, 1, "fifth_take_ignored_full"); push(K_ID, 0, 0, "fifth_take_ignored_id");
      @(negedge clk);
      while (sb.size() != 0) begin e = sb.pop_front(); checks++; if (obs(e.kind, e.lane) !== e.val) begin errors++; $display("FAIL %s: got %0h required %0h", e.name, obs(e.kind, e.lane), e.val); end end
      tick();
      ckptTake = 1;
      push(K_FULL, 0, 0, "release_frees_slot"); push(K_ID, 0, 0, "take_at_wrapped_tail");
      @(negedge clk);
      while (sb.size() != 0) begin e = sb.pop_front(); checks++; if (obs(e.kind, e.lane) !== e.val) begin errors++; $display("FAIL %s: got %0h required %0h", e.name, obs(e.kind, e.lane), e.val); end end
      tick();
      push(K_FULL, 0, 1, "refull_after_take"); push(K_ID, 0, 1, "tail_after_wrap_take");
      @(negedge clk);
      while (sb.size() != 0) begin e = sb.pop_front(); checks++; if (obs(e.kind, e.lane) !== e.val) begin errors++; $display("FAIL %s: got %0h required %0h", e.name, obs(e.kind, e.lane), e.val); end end
      tick();
   endtask

   task automatic test_x0();
      ren(0, 0, 5); src(0, 0, 0); src(1, 0, 0);
      push(K_B1, 1, 0, "x0_bypass_busy1"); push(K_R1, 1, 0, "x0_bypass_rob1");
      push(K_B2, 1, 0, "x0_bypass_busy2"); push(K_R1, 0, 0, "x0_rob_l0");
      @(negedge clk);
      while (sb.size() != 0) begin e = sb.pop_front(); checks++; if (obs(e.kind, e.lane) !== e.val) begin errors++; $display("FAIL %s: got %0h required %0h", e.name, obs(e.kind, e.lane), e.val); end end
      tick();
      src(1, 0, 0);
      push(K_B1, 1, 0, "x0_after_write_busy"); push(K_R1, 1, 0, "x0_after_write_rob");
      @(negedge clk);
      while (sb.size() != 0) begin e = sb.pop_front(); checks++; if (obs(e.kind, e.lane) !== e.val) begin errors++; $display("FAIL %s: got %0h required %0h", e.name, obs(e.kind, e.lane), e.val); end end
      tick();
   endtask

   task automatic test_flush();
      ren(0, 9, 5);
      tick();
      src(0, 9, 0);
      push(K_B1, 0, 1, "pre_flush_busy_x9"); push(K_FULL, 0, 1, "pre_flush_full");
      @(negedge clk);
      while (sb.size() != 0) begin e = sb.pop_front(); checks++; if (obs(e.kind, e.lane) !== e.val) begin errors++; $display("FAIL %s: got %0h required %0h", e.name, obs(e.kind, e.lane), e.val); end end
      tick();
      flush = 1; ren(1, 12, 3);
      tick();
      src(0, 9, 12); src(1, 7, 10);
      push(K_B1, 0, 0, "flush_busy_x9"); push(K_B2, 0, 0, "flush_drops_rename_x12");
      push(K_B1, 1, 0, "flush_busy_x7"); push(K_B2, 1, 0, "flush_busy_x10");
      push(K_FULL, 0, 0, "flush_ckptFull"); push(K_ID, 0, 0, "flush_ckptId");
      @(negedge clk);
      while (sb.size() != 0) begin e = sb.pop_front(); checks++; if (obs(e.kind, e.lane) !== e.val) begin errors++; $display("FAIL %s: got %0h required %0h", e.name, obs(e.kind, e.lane), e.val); end end
      tick();
   endtask

   initial begin
      idle();
      globalReset = 1;
      test_reset();
      test_bypass();
      test_commit();
      test_commit_rename();
      test_back_to_back();
      test_restore();
      test_ckpt_full();
      test_x0();
      test_flush();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
